// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the CONV PE sequencer.
// The state enum and counter-width arithmetic live here so that the top and the raster counter use the same definitions.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_RST,
    S_RUN,
    S_FIN,
    S_WAIT,
    S_DRAIN
  } seq_state_e;

  // Accumulation window of one pixel at the largest tile count.
  function automatic int acc_max(input int max_tiles, input int kernel_w);
    return max_tiles * kernel_w * kernel_w;
  endfunction

  // The cycle counter is shared by the LEAD, RUN and DRAIN phases, so it must hold the longest of the three.
  function automatic int cnt_width(input int max_tiles, input int kernel_w,
                                   input int start_delay, input int drain_cycles);
    int span;
    span = acc_max(max_tiles, kernel_w);
    if (start_delay > span) span = start_delay;
    if (drain_cycles > span) span = drain_cycles;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/conv_pix_counter.sv
// Raster-order OFM pixel counter: x runs fastest and wraps at the latched width.
// last flags the final pixel of the layer.
module conv_pix_counter
  import conv_seq_pkg::*;
#(
  parameter int DIM_W = 9,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_h,
  output logic [PIX_W-1:0] x,
  output logic [PIX_W-1:0] y,
  output logic             last
);

  logic x_end;
  logic y_end;

  assign x_end = (DIM_W'(x) == cfg_w - 1'b1);
  assign y_end = (DIM_W'(y) == cfg_h - 1'b1);
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x_end) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_pe_sequencer.sv
// Control sequencer for the CONV PE array. For each OFM pixel it issues a one-cycle PE_reset, waits out the accumulation
// window and then issues a one-cycle PE_finish. Pixels are walked in raster order, and the sequencer handles stall, abort and drain.
module conv_pe_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_PE       = 16,
  parameter int KERNEL_W     = 3,
  parameter int MAX_TILES    = 16,
  parameter int MAX_OFM_DIM  = 256,
  parameter int START_DELAY  = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cal_start,
  input  logic                             cal_abort,
  input  logic [$clog2(MAX_TILES+1)-1:0]   cfg_tiles,
  input  logic [$clog2(MAX_OFM_DIM+1)-1:0] cfg_ofm_w,
  input  logic [$clog2(MAX_OFM_DIM+1)-1:0] cfg_ofm_h,
  input  logic [NUM_PE-1:0]                cfg_pe_mask,
  input  logic                             ofm_stall,
  output logic [NUM_PE-1:0]                PE_reset,
  output logic [NUM_PE-1:0]                PE_finish,
  output logic [$clog2(MAX_OFM_DIM)-1:0]   pix_x,
  output logic [$clog2(MAX_OFM_DIM)-1:0]   pix_y,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);

  localparam int TILE_W = $clog2(MAX_TILES + 1);
  localparam int DIM_W  = $clog2(MAX_OFM_DIM + 1);
  localparam int PIX_W  = $clog2(MAX_OFM_DIM);
  localparam int KK     = KERNEL_W * KERNEL_W;
  localparam int CNT_W  = cnt_width(MAX_TILES, KERNEL_W, START_DELAY, DRAIN_CYCLES);

  localparam logic [CNT_W-1:0]  LEAD_LAST  = CNT_W'((START_DELAY >= 2) ? START_DELAY - 2 : 0);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'((DRAIN_CYCLES >= 1) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [TILE_W-1:0] TILES_MAX  = TILE_W'(MAX_TILES);
  localparam logic [DIM_W-1:0]  DIM_MAX    = DIM_W'(MAX_OFM_DIM);

  if (KK < 3) begin : g_bad_kernel
    $error("KERNEL_W*KERNEL_W must be at least 3");
  end
  if (START_DELAY < 1) begin : g_bad_start_delay
    $error("START_DELAY must be at least 1");
  end

  seq_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  run_last_q, run_last_d;
  logic [DIM_W-1:0]  w_q, h_q;
  logic [NUM_PE-1:0] mask_q;
  logic              cfg_ok;
  logic              latch;
  logic              err_now;
  logic              drain_end;
  logic              done_pend;
  logic              pix_inc, pix_clr, pix_last;
  logic [PIX_W-1:0]  cur_x, cur_y;

  assign cfg_ok = (cfg_tiles != '0) && (cfg_tiles <= TILES_MAX) &&
                  (cfg_ofm_w != '0) && (cfg_ofm_w <= DIM_MAX) &&
                  (cfg_ofm_h != '0) && (cfg_ofm_h <= DIM_MAX) &&
                  (cfg_pe_mask != '0);

  // RST and FIN each take one cycle of the ACC-cycle pixel period, so RUN counts 0..ACC-3.
  assign run_last_d = CNT_W'(int'(cfg_tiles) * KK - 3);

  conv_pix_counter #(
    .DIM_W (DIM_W),
    .PIX_W (PIX_W)
  ) u_pix (
    .clk   (clk),
    .rst_n (reset),
    .clr   (pix_clr),
    .inc   (pix_inc),
    .cfg_w (w_q),
    .cfg_h (h_q),
    .x     (cur_x),
    .y     (cur_y),
    .last  (pix_last)
  );

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    latch      = 1'b0;
    err_now    = 1'b0;
    pix_inc    = 1'b0;
    pix_clr    = 1'b0;
    drain_end  = 1'b0;
    if ((state != S_IDLE) && cal_abort) begin
      state_next = S_IDLE;
      pix_clr    = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cal_start && !cal_abort) begin
            if (cfg_ok) begin
              latch      = 1'b1;
              pix_clr    = 1'b1;
              state_next = (START_DELAY > 1) ? S_LEAD : S_RST;
            end else begin
              err_now = 1'b1;
            end
          end
        end
        S_LEAD: begin
          if (cnt == LEAD_LAST) state_next = S_RST;
          else                  cnt_next   = cnt + 1'b1;
        end
        S_RST: state_next = S_RUN;
        S_RUN: begin
          if (cnt == run_last_q) state_next = S_FIN;
          else                   cnt_next   = cnt + 1'b1;
        end
        S_FIN: begin
          if (pix_last) begin
            if (DRAIN_CYCLES == 0) begin
              state_next = S_IDLE;
              drain_end  = 1'b1;
            end else begin
              state_next = S_DRAIN;
            end
          end else begin
            pix_inc    = 1'b1;
            state_next = ofm_stall ? S_WAIT : S_RST;
          end
        end
        S_WAIT: begin
          if (!ofm_stall) state_next = S_RST;
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state_next = S_IDLE;
            drain_end  = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      run_last_q <= '0;
      w_q        <= '0;
      h_q        <= '0;
      mask_q     <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch) begin
        run_last_q <= run_last_d;
        w_q        <= cfg_ofm_w;
        h_q        <= cfg_ofm_h;
        mask_q     <= cfg_pe_mask;
      end
    end
  end

  // Outputs are decoded from the registered state one cycle late. Abort is folded in here so that it clears them on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PE_reset  <= '0;
      PE_finish <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      busy      <= 1'b0;
      done_pend <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      PE_reset  <= ((state == S_RST) && !cal_abort) ? mask_q : '0;
      PE_finish <= ((state == S_FIN) && !cal_abort) ? mask_q : '0;
      pix_x     <= cur_x;
      pix_y     <= cur_y;
      busy      <= (state != S_IDLE) && !cal_abort;
      done_pend <= drain_end;
      done      <= done_pend;
      cfg_err   <= err_now;
    end
  end

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed and randomized bench for conv_pe_sequencer. Each layer's expected event times are computed arithmetically
// from the tile count, OFM size and stall lengths, then compared against the DUT cycle by cycle.
module tb_conv_pe_sequencer;

  localparam int NPE = 16;
  localparam int KW  = 3;
  localparam int SD  = 3;
  localparam int DR  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            cal_start, cal_abort, ofm_stall;
  logic [4:0]      cfg_tiles;
  logic [8:0]      cfg_ofm_w, cfg_ofm_h;
  logic [NPE-1:0]  cfg_pe_mask;
  logic [NPE-1:0]  PE_reset, PE_finish;
  logic [7:0]      pix_x, pix_y;
  logic            busy, done, cfg_err;

  int vectors = 0;
  int miscompares = 0;
  int t_rst[64];
  int t_fin[64];
  int stall_len[64];

  conv_pe_sequencer #(
    .NUM_PE       (NPE),
    .KERNEL_W     (KW),
    .MAX_TILES    (16),
    .MAX_OFM_DIM  (256),
    .START_DELAY  (SD),
    .DRAIN_CYCLES (DR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cal_start   (cal_start),
    .cal_abort   (cal_abort),
    .cfg_tiles   (cfg_tiles),
    .cfg_ofm_w   (cfg_ofm_w),
    .cfg_ofm_h   (cfg_ofm_h),
    .cfg_pe_mask (cfg_pe_mask),
    .ofm_stall   (ofm_stall),
    .PE_reset    (PE_reset),
    .PE_finish   (PE_finish),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 64; i++) stall_len[i] = 0;
  endtask

  // Stall is held from the FIN cycle for stall_len cycles. A one-cycle blip during each RUN must be ignored.
  function automatic logic stall_on(input int c, input int npix);
    for (int p = 0; p < npix; p++) begin
      if (c >= t_fin[p] - 1 && c < t_fin[p] - 1 + stall_len[p]) return 1'b1;
      if (c == t_rst[p] + 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_layer(input int tiles, input int w, input int h,
                           input logic [NPE-1:0] m, input int abort_at);
    int acc, npix, t, done_t, last_c, px;
    logic [NPE-1:0] er, ef;
    logic eb, ed;
    acc  = tiles * KW * KW;
    npix = w * h;
    t    = SD;
    for (int p = 0; p < npix; p++) begin
      t_rst[p] = t;
      t_fin[p] = t + acc - 1;
      t = t + acc + ((p < npix - 1) ? stall_len[p] : 0);
    end
    done_t = t_fin[npix-1] + 1 + DR;
    last_c = (abort_at >= 0) ? abort_at + 60 : done_t + 3;
    cfg_tiles   = 5'(tiles);
    cfg_ofm_w   = 9'(w);
    cfg_ofm_h   = 9'(h);
    cfg_pe_mask = m;
    cal_start   = 1'b1;
    tick();
    cal_start = 1'b0;
    for (int c = 0; c <= last_c; c++) begin
      ofm_stall = stall_on(c, npix);
      cal_abort = (c == abort_at);
      er = '0;
      ef = '0;
      px = -1;
      for (int p = 0; p < npix; p++) begin
        if (c == t_rst[p]) begin er = m; px = p; end
        if (c == t_fin[p]) begin ef = m; px = p; end
      end
      eb = (c >= 1) && (c < done_t);
      ed = (c == done_t);
      if (c == done_t) px = npix - 1;
      if (abort_at >= 0 && c > abort_at) begin
        er = '0; ef = '0; eb = 1'b0; ed = 1'b0; px = -1;
      end
      chk("pe_reset", PE_reset, er);
      chk("pe_finish", PE_finish, ef);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("cfg_err", cfg_err, 1'b0);
      if (px >= 0) begin
        chk("pix_x", pix_x, px % w);
        chk("pix_y", pix_y, px / w);
      end
      tick();
    end
    ofm_stall = 1'b0;
    cal_abort = 1'b0;
  endtask

  task automatic bad_start(input int tiles, input int w, input int h, input logic [NPE-1:0] m);
    cfg_tiles   = 5'(tiles);
    cfg_ofm_w   = 9'(w);
    cfg_ofm_h   = 9'(h);
    cfg_pe_mask = m;
    cal_start   = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1'b1);
    chk("cfg_err_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cfg_err_low", cfg_err, 1'b0);
      chk("cfg_err_idle", busy, 1'b0);
      chk("cfg_err_strobe", PE_reset, '0);
    end
  endtask

  initial begin
    int tiles, w, h;
    logic [NPE-1:0] m;
    reset = 1'b0;
    cal_start = 1'b0;
    cal_abort = 1'b0;
    ofm_stall = 1'b0;
    cfg_tiles = '0;
    cfg_ofm_w = '0;
    cfg_ofm_h = '0;
    cfg_pe_mask = '0;
    clear_stalls();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pe_reset", PE_reset, '0);
    chk("rst_pe_finish", PE_finish, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_pix", {pix_y, pix_x}, '0);
    reset = 1'b1;
    tick();

    // Nominal 2x2 layer, 4 tiles.
    run_layer(4, 2, 2, 16'hFFFF, -1);

    // Stall held for 10 cycles from the first FIN.
    stall_len[0] = 10;
    run_layer(4, 2, 2, 16'hFFFF, -1);
    clear_stalls();

    // Abort in the middle of pixel 1's RUN, followed by a fresh start.
    run_layer(4, 2, 2, 16'hFFFF, SD + 36 + 5);
    run_layer(4, 2, 2, 16'hFFFF, -1);

    // Rejected starts.
    bad_start(0, 2, 2, 16'hFFFF);
    bad_start(4, 2, 2, 16'h0000);
    bad_start(17, 2, 2, 16'hFFFF);
    bad_start(4, 0, 2, 16'hFFFF);
    bad_start(4, 2, 300, 16'hFFFF);

    // Reset asserted during the RUN phase of pixel 1.
    cfg_tiles = 5'd4;
    cfg_ofm_w = 9'd2;
    cfg_ofm_h = 9'd2;
    cfg_pe_mask = 16'hFFFF;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (50) tick();
    chk("mid_busy", busy, 1'b1);
    chk("mid_pix_x", pix_x, 8'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_pix", {pix_y, pix_x}, '0);
    chk("arst_pe_reset", PE_reset, '0);
    chk("arst_pe_finish", PE_finish, '0);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_strobe", PE_reset | PE_finish, '0);
    end

    // Partial mask with the minimum tile count.
    run_layer(1, 3, 1, 16'h00FF, -1);

    // Randomized layers, each with random per-pixel stalls.
    for (int it = 0; it < 8; it++) begin
      tiles = $urandom_range(1, 4);
      w = $urandom_range(1, 3);
      h = $urandom_range(1, 3);
      m = NPE'($urandom);
      if (m == '0) m = 16'h0001;
      for (int p = 0; p < 64; p++)
        stall_len[p] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      run_layer(tiles, w, h, m, -1);
      clear_stalls();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
